// File: rtl/count_driver.sv
// Step sequencer for a loadable up/down position counter: walks a shadow
// position toward a target at a programmable rate and forwards explicit loads.
module count_driver #(
    parameter int unsigned W  = 10,
    parameter int unsigned RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [W-1:0]  i_target,
    input  logic [RW-1:0] i_rate,
    input  logic          i_abort,
    input  logic          i_pos_ld,
    input  logic [W-1:0]  i_pos_d,
    output logic          o_up,
    output logic          o_dw,
    output logic          o_ld,
    output logic [W-1:0]  o_d,
    output logic          o_ce,
    output logic          o_busy,
    output logic          o_done,
    output logic [W-1:0]  o_pos
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_tgt, w_tgt_nxt;
    logic [RW-1:0] r_rcfg, w_rcfg_nxt;
    logic [RW-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]  r_pos, w_pos_nxt;
    logic [W-1:0]  r_d, w_d_nxt;
    logic          r_up, w_up_nxt;
    logic          r_dw, w_dw_nxt;
    logic          r_ld, w_ld_nxt;
    logic          r_ce;
    logic          r_done, w_done_nxt;
    logic          r_busy;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_rcfg  <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_d     <= '0;
            r_up    <= 1'b0;
            r_dw    <= 1'b0;
            r_ld    <= 1'b0;
            r_ce    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_rcfg  <= w_rcfg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_d     <= w_d_nxt;
            r_up    <= w_up_nxt;
            r_dw    <= w_dw_nxt;
            r_ld    <= w_ld_nxt;
            r_ce    <= w_up_nxt | w_dw_nxt | w_ld_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
        end
    end

    // Next-state and pulse decode; abort outranks load, load outranks start
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_rcfg_nxt  = r_rcfg;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_d_nxt     = r_d;
        w_up_nxt    = 1'b0;
        w_dw_nxt    = 1'b0;
        w_ld_nxt    = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_pos_ld) begin
                    w_pos_nxt = i_pos_d;
                    w_d_nxt   = i_pos_d;
                    w_ld_nxt  = 1'b1;
                end else if (i_start) begin
                    if (i_target == r_pos) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_tgt_nxt   = i_target;
                        w_rcfg_nxt  = i_rate;
                        w_cnt_nxt   = i_rate;
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - RW'(1);
                end else begin
                    // Direction comes from magnitude compare, so pos never wraps
                    w_cnt_nxt = r_rcfg;
                    if (r_tgt > r_pos) begin
                        w_up_nxt  = 1'b1;
                        w_pos_nxt = r_pos + W'(1);
                    end else if (r_tgt < r_pos) begin
                        w_dw_nxt  = 1'b1;
                        w_pos_nxt = r_pos - W'(1);
                    end
                    if (w_pos_nxt == r_tgt) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_up   = r_up;
    assign o_dw   = r_dw;
    assign o_ld   = r_ld;
    assign o_d    = r_d;
    assign o_ce   = r_ce;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_pos  = r_pos;

endmodule

// File: tb/tb_count_driver.sv
// Self-checking bench for count_driver: per-cycle vector table through a
// scoreboard queue, plus hand sequences for long moves, abort and reset.
module tb_count_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, pos_ld;
    logic [9:0] target, pos_d;
    logic [7:0] rate;
    logic       up, dw, ld, ce, busy, done;
    logic [9:0] d, pos;
    logic [9:0] q;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    count_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_target (target),
        .i_rate   (rate),
        .i_abort  (abort),
        .i_pos_ld (pos_ld),
        .i_pos_d  (pos_d),
        .o_up     (up),
        .o_dw     (dw),
        .o_ld     (ld),
        .o_d      (d),
        .o_ce     (ce),
        .o_busy   (busy),
        .o_done   (done),
        .o_pos    (pos)
    );

    // Downstream position counter model driven by the DUT outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= d;
        else if (up) q <= q + 10'd1;
        else if (dw) q <= q - 10'd1;
    end

    typedef struct packed {
        logic       up;
        logic       dw;
        logic       ld;
        logic       done;
        logic       busy;
        logic [9:0] pos;
        logic [9:0] q;
    } exp_t;

    typedef struct {
        logic       start;
        logic [9:0] target;
        logic [7:0] rate;
        logic       abort;
        logic       pos_ld;
        logic [9:0] pos_d;
        exp_t       e;
    } vec_t;

    localparam int NV = 25;
    vec_t       vecs[NV];
    exp_t       sb_q[$];
    logic [9:0] fin_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [9:0] tg, input logic [7:0] rt,
                                input logic ab, input logic pl, input logic [9:0] pd,
                                input logic eu, input logic edw, input logic el,
                                input logic edn, input logic eb,
                                input logic [9:0] ep, input logic [9:0] eq);
        vec_t v;
        v.start = st; v.target = tg; v.rate = rt;
        v.abort = ab; v.pos_ld = pl; v.pos_d = pd;
        v.e = '{up: eu, dw: edw, ld: el, done: edn, busy: eb, pos: ep, q: eq};
        return v;
    endfunction

    task automatic drive_idle();
        start = 1'b0; abort = 1'b0; pos_ld = 1'b0;
        target = '0; rate = '0; pos_d = '0;
    endtask

    task automatic apply_row(input int i);
        exp_t e;
        @(negedge clk);
        start  = vecs[i].start;  target = vecs[i].target; rate  = vecs[i].rate;
        abort  = vecs[i].abort;  pos_ld = vecs[i].pos_ld; pos_d = vecs[i].pos_d;
        sb_q.push_back(vecs[i].e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("row%0d pulses{up,dw,ld,ce,done,busy}", i),
            32'({up, dw, ld, ce, done, busy}),
            32'({e.up, e.dw, e.ld, e.up | e.dw | e.ld, e.done, e.busy}));
        chk($sformatf("row%0d pos", i), 32'(pos), 32'(e.pos));
        chk($sformatf("row%0d counter_q", i), 32'(q), 32'(e.q));
        if (e.ld) chk($sformatf("row%0d d", i), 32'(d), 32'(e.pos));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_up, n_dw, n_done;
        logic got_done;

        //         st tgt  rt ab pl pd    up dw ld dn b  pos  q
        vecs[0]  = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
        vecs[1]  = mk(0, 0,   0, 0, 1, 100, 0, 0, 1, 0, 0, 100, 0);
        vecs[2]  = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 100, 100);
        vecs[3]  = mk(1, 103, 0, 0, 0, 0,   0, 0, 0, 0, 1, 100, 100);
        vecs[4]  = mk(0, 0,   0, 0, 0, 0,   1, 0, 0, 0, 1, 101, 100);
        vecs[5]  = mk(0, 0,   0, 0, 0, 0,   1, 0, 0, 0, 1, 102, 101);
        vecs[6]  = mk(0, 0,   0, 0, 0, 0,   1, 0, 0, 1, 0, 103, 102);
        vecs[7]  = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 103, 103);
        vecs[8]  = mk(1, 103, 0, 0, 0, 0,   0, 0, 0, 1, 0, 103, 103);
        vecs[9]  = mk(1, 50,  0, 0, 1, 5,   0, 0, 1, 0, 0, 5,   103);
        vecs[10] = mk(0, 0,   0, 1, 1, 7,   0, 0, 0, 0, 0, 5,   5);
        vecs[11] = mk(1, 2,   3, 0, 0, 0,   0, 0, 0, 0, 1, 5,   5);
        vecs[12] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 5,   5);
        vecs[13] = mk(0, 0,   0, 0, 1, 77,  0, 0, 0, 0, 1, 5,   5);
        vecs[14] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 5,   5);
        vecs[15] = mk(0, 0,   0, 0, 0, 0,   0, 1, 0, 0, 1, 4,   5);
        vecs[16] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 4,   4);
        vecs[17] = mk(1, 900, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4,   4);
        vecs[18] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 4,   4);
        vecs[19] = mk(0, 0,   0, 0, 0, 0,   0, 1, 0, 0, 1, 3,   4);
        vecs[20] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   3);
        vecs[21] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   3);
        vecs[22] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   3);
        vecs[23] = mk(0, 0,   0, 0, 0, 0,   0, 1, 0, 1, 0, 2,   3);
        vecs[24] = mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 2,   2);

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'({up, dw, ld, ce, done, busy}), 32'd0);
        chk("reset pos", 32'(pos), 32'd0);
        chk("reset d", 32'(d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) apply_row(i);

        // Full-range climb 0 -> 1023 at one step per cycle
        @(negedge clk);
        pos_ld = 1'b1; pos_d = 10'd0;
        @(negedge clk);
        drive_idle();
        start = 1'b1; target = 10'd1023; rate = 8'd0;
        fin_q.push_back(10'd1023);
        @(negedge clk);
        drive_idle();
        n_up = 0; n_dw = 0; got_done = 1'b0;
        for (int c = 0; c < 1200 && !got_done; c++) begin
            @(posedge clk);
            #1;
            if (up) n_up++;
            if (dw) n_dw++;
            if (done) begin
                got_done = 1'b1;
                chk("climb done with final up", 32'(up), 32'd1);
                chk("climb busy at done", 32'(busy), 32'd0);
            end
        end
        chk("climb done seen", 32'(got_done), 32'd1);
        chk("climb up count", 32'(n_up), 32'd1023);
        chk("climb dw count", 32'(n_dw), 32'd0);
        chk("climb final pos", 32'(pos), 32'(fin_q.pop_front()));
        @(posedge clk);
        #1;
        chk("climb counter_q", 32'(q), 32'd1023);
        chk("climb no wrap pulse", 32'({up, dw}), 32'd0);

        // Equal target at top of range: immediate done, no step
        @(negedge clk);
        start = 1'b1; target = 10'd1023;
        @(posedge clk);
        #1;
        chk("equal done", 32'({done, up, dw, busy}), 32'b1000);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        chk("equal done one cycle", 32'(done), 32'd0);

        // Abort after the 4th pulse of a 10-step move; mid-move start/load ignored
        @(negedge clk);
        pos_ld = 1'b1; pos_d = 10'd200;
        @(negedge clk);
        drive_idle();
        start = 1'b1; target = 10'd210; rate = 8'd1;
        @(negedge clk);
        drive_idle();
        n_up = 0;
        for (int c = 0; c < 50 && n_up < 4; c++) begin
            @(posedge clk);
            #1;
            if (up) n_up++;
            if (c == 1) begin
                pos_ld = 1'b1; pos_d = 10'd999; start = 1'b1; target = 10'd0;
            end else begin
                drive_idle();
            end
        end
        chk("abort pre-pulses", 32'(n_up), 32'd4);
        chk("abort pos before", 32'(pos), 32'd204);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy drop", 32'({busy, done, up, dw}), 32'd0);
        @(negedge clk);
        drive_idle();
        n_up = 0; n_dw = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (up) n_up++;
            if (dw) n_dw++;
            if (done) n_done++;
        end
        chk("abort no pulses", 32'(n_up + n_dw), 32'd0);
        chk("abort no done", 32'(n_done), 32'd0);
        chk("abort pos kept", 32'(pos), 32'd204);
        chk("abort counter_q", 32'(q), 32'd204);

        // Asynchronous reset in the middle of a move
        @(negedge clk);
        pos_ld = 1'b1; pos_d = 10'd300;
        @(negedge clk);
        drive_idle();
        start = 1'b1; target = 10'd320; rate = 8'd0;
        @(negedge clk);
        drive_idle();
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({up, dw, ld, ce, done, busy}), 32'd0);
        chk("async reset pos", 32'(pos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_up = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (up || busy) n_up++;
        end
        chk("post-reset idle", 32'(n_up), 32'd0);
        @(negedge clk);
        start = 1'b1; target = 10'd0;
        @(posedge clk);
        #1;
        chk("post-reset equal done", 32'({done, busy}), 32'b10);
        @(negedge clk);
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
